// File: rtl/bus_arbiter_mc_pkg.sv
// rtl/bus_arbiter_mc_pkg.sv - shared types, arbitration constants and round-robin search for bus_arbiter_mc
package bus_mc_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      POP     = 2'd1,
      ROUTE   = 2'd2,
      DELIVER = 2'd3
   } state_t;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;
   localparam int MAX_DRVRS = 32;

   // First set bit of mask at or after ptr+1, wrapping modulo n; fixed priority is ptr = n-1.
   function automatic int unsigned next_rr(input logic [MAX_DRVRS-1:0] mask,
                                           input int unsigned ptr,
                                           input int unsigned n);
      int unsigned res;
      logic        found;
      logic [4:0]  idx;
      res   = ptr;
      found = 1'b0;
      for (int unsigned k = 1; k <= MAX_DRVRS; k++) begin
         if (!found && k <= n) begin
            idx = 5'((ptr + k) % n);
            if (mask[idx]) begin
               found = 1'b1;
               res   = 32'(idx);
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/bus_arbiter_mc_if.sv
// rtl/bus_arbiter_mc_if.sv - device FIFO side signals of all buses, with arbiter and device modports
interface bus_arbiter_mc_if #(
   parameter int BITS    = 1,
   parameter int DRVRS   = 4,
   parameter int PCKG_SZ = 16,
   parameter int CNT_W   = 8
);
   logic [BITS-1:0][DRVRS-1:0]              pndng;
   logic [BITS-1:0][DRVRS-1:0][PCKG_SZ-1:0] D_pop;
   logic [BITS-1:0][DRVRS-1:0]              pop;
   logic [BITS-1:0][DRVRS-1:0]              full;
   logic [BITS-1:0][DRVRS-1:0]              push;
   logic [BITS-1:0][DRVRS-1:0][PCKG_SZ-1:0] D_push;
   logic [BITS-1:0]                         busy;
   logic [BITS-1:0][CNT_W-1:0]              drop_cnt;

   modport master (
      input  pndng, D_pop, full,
      output pop, push, D_push, busy, drop_cnt
   );

   modport slave (
      output pndng, D_pop, full,
      input  pop, push, D_push, busy, drop_cnt
   );
endinterface

// File: rtl/bus_arbiter_mc_channel.sv
// rtl/bus_arbiter_mc_channel.sv - one bus: arbiter, pop/route/deliver FSM and drop counter
module bus_channel
   import bus_mc_pkg::*;
#(
   parameter int              drvrs     = 4,
   parameter int              pckg_sz   = 16,
   parameter int              id_w      = 8,
   parameter logic [id_w-1:0] broadcast = {id_w{1'b1}},
   parameter int              arb_mode  = ARB_RR,
   parameter int              cnt_w     = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [drvrs-1:0]               pndng,
   input  logic [drvrs-1:0][pckg_sz-1:0]  d_pop,
   input  logic [drvrs-1:0]               full,
   output logic [drvrs-1:0]               pop,
   output logic [drvrs-1:0]               push,
   output logic [drvrs-1:0][pckg_sz-1:0]  d_push,
   output logic                           busy,
   output logic [cnt_w-1:0]               drop_cnt
);
   localparam int IW = (drvrs > 1) ? $clog2(drvrs) : 1;
   localparam logic [drvrs-1:0] ONE = drvrs'(1);

   state_t                          state_q, state_d;
   logic [IW-1:0]                   w_q, w_d;
   logic [IW-1:0]                   ptr_q, ptr_d;
   logic [pckg_sz-1:0]              pkt_q, pkt_d;
   logic [drvrs-1:0]                mask_q, mask_d;
   logic [cnt_w-1:0]                drop_cnt_q, drop_cnt_d;
   logic [drvrs-1:0]                pop_q, pop_d;
   logic [drvrs-1:0]                push_q, push_d;
   logic [drvrs-1:0][pckg_sz-1:0]   d_push_q, d_push_d;
   logic                            busy_q, busy_d;

   logic [MAX_DRVRS-1:0]            req_ext;
   int unsigned                     arb_base;
   logic [IW-1:0]                   win;
   logic [id_w-1:0]                 dest_id;
   logic [drvrs-1:0]                route_mask;

   always_comb begin
      state_d    = state_q;
      w_d        = w_q;
      ptr_d      = ptr_q;
      pkt_d      = pkt_q;
      mask_d     = mask_q;
      drop_cnt_d = drop_cnt_q;
      pop_d      = '0;
      push_d     = '0;
      d_push_d   = d_push_q;

      req_ext  = MAX_DRVRS'(pndng);
      arb_base = (arb_mode == ARB_RR) ? 32'(ptr_q) : 32'(drvrs - 1);
      win      = IW'(next_rr(req_ext, arb_base, 32'(drvrs)));

      // An empty mask (bad ID, or broadcast with a single device) means drop.
      dest_id    = pkt_q[pckg_sz-1 -: id_w];
      route_mask = '0;
      if (dest_id == broadcast) begin
         route_mask = ~(ONE << w_q);
      end else if (32'(dest_id) < 32'(drvrs)) begin
         route_mask = ONE << dest_id;
      end

      case (state_q)
         IDLE: begin
            if (|pndng) begin
               w_d   = win;
               if (arb_mode == ARB_RR) ptr_d = win;
               pop_d   = ONE << win;
               state_d = POP;
            end
         end
         POP: begin
            pkt_d   = d_pop[w_q];
            state_d = ROUTE;
         end
         ROUTE: begin
            if (route_mask == '0) begin
               if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + cnt_w'(1);
               state_d = IDLE;
            end else begin
               mask_d  = route_mask;
               state_d = DELIVER;
            end
         end
         DELIVER: begin
            // All targets must have room; a broadcast is never split across cycles.
            if ((full & mask_q) == '0) begin
               push_d   = mask_q;
               d_push_d = {drvrs{pkt_q}};
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         w_q        <= '0;
         ptr_q      <= IW'(drvrs - 1);
         pkt_q      <= '0;
         mask_q     <= '0;
         drop_cnt_q <= '0;
         pop_q      <= '0;
         push_q     <= '0;
         d_push_q   <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         w_q        <= w_d;
         ptr_q      <= ptr_d;
         pkt_q      <= pkt_d;
         mask_q     <= mask_d;
         drop_cnt_q <= drop_cnt_d;
         pop_q      <= pop_d;
         push_q     <= push_d;
         d_push_q   <= d_push_d;
         busy_q     <= busy_d;
      end
   end

   assign pop      = pop_q;
   assign push     = push_q;
   assign d_push   = d_push_q;
   assign busy     = busy_q;
   assign drop_cnt = drop_cnt_q;

endmodule

// File: rtl/bus_arbiter_mc.sv
// rtl/bus_arbiter_mc.sv - multi-channel packet bus arbiter, one independent channel per bus
module bus_arbiter_mc
   import bus_mc_pkg::*;
#(
   parameter int              bits      = 1,
   parameter int              drvrs     = 4,
   parameter int              pckg_sz   = 16,
   parameter int              id_w      = 8,
   parameter logic [id_w-1:0] broadcast = {id_w{1'b1}},
   parameter int              arb_mode  = ARB_RR,
   parameter int              cnt_w     = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   bus_arbiter_mc_if.master     bus
);

   for (genvar b = 0; b < bits; b++) begin : g_bus
      bus_channel #(
         .drvrs     (drvrs),
         .pckg_sz   (pckg_sz),
         .id_w      (id_w),
         .broadcast (broadcast),
         .arb_mode  (arb_mode),
         .cnt_w     (cnt_w)
      ) u_channel (
         .clk      (clk),
         .reset    (reset),
         .pndng    (bus.pndng[b]),
         .d_pop    (bus.D_pop[b]),
         .full     (bus.full[b]),
         .pop      (bus.pop[b]),
         .push     (bus.push[b]),
         .d_push   (bus.D_push[b]),
         .busy     (bus.busy[b]),
         .drop_cnt (bus.drop_cnt[b])
      );
   end

endmodule

// File: tb/tb_bus_arbiter_mc.sv
// tb/tb_bus_arbiter_mc.sv - directed self-checking bench for bus_arbiter_mc
module tb_bus_arbiter_mc;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   bus_arbiter_mc_if #(.BITS(2), .DRVRS(4), .PCKG_SZ(16), .CNT_W(8)) if_rr ();
   bus_arbiter_mc_if #(.BITS(1), .DRVRS(4), .PCKG_SZ(16), .CNT_W(8)) if_fx ();

   bus_arbiter_mc #(.bits(2), .drvrs(4), .pckg_sz(16), .id_w(8), .broadcast(8'hFF),
                    .arb_mode(1), .cnt_w(8))
      dut_rr (.clk(clk), .reset(reset), .bus(if_rr));

   bus_arbiter_mc #(.bits(1), .drvrs(4), .pckg_sz(16), .id_w(8), .broadcast(8'hFF),
                    .arb_mode(0), .cnt_w(8))
      dut_fx (.clk(clk), .reset(reset), .bus(if_fx));

   logic [1:0][3:0]       man_pndng;
   logic [1:0][3:0]       man_full;
   logic [1:0][3:0][15:0] man_dpop;
   logic                  use_fifo;
   logic                  fifo_clr;
   logic [3:0][1:0]       popped_rr, popped_fx;
   logic [3:0]            fifo_pndng_rr, fifo_pndng_fx;
   logic [3:0][15:0]      fifo_data;

   int checks = 0;
   int failures = 0;
   int g_rr[$];
   int g_fx[$];

   // Three-deep device FIFOs for the fairness run; each device sends to its neighbour.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         fifo_pndng_rr[i] = (popped_rr[i] != 2'd3);
         fifo_pndng_fx[i] = (popped_fx[i] != 2'd3);
         fifo_data[i]     = {6'b0, 2'(i + 1), 8'(i)};
      end
   end

   always @(posedge clk) begin
      if (fifo_clr) begin
         popped_rr <= '0;
         popped_fx <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (if_rr.pop[0][i]) popped_rr[i] <= popped_rr[i] + 2'd1;
            if (if_fx.pop[0][i]) popped_fx[i] <= popped_fx[i] + 2'd1;
         end
      end
   end

   assign if_rr.pndng = use_fifo ? {4'b0, fifo_pndng_rr} : man_pndng;
   assign if_rr.D_pop = use_fifo ? {64'b0, fifo_data} : man_dpop;
   assign if_rr.full  = man_full;
   assign if_fx.pndng = use_fifo ? fifo_pndng_fx : 4'b0;
   assign if_fx.D_pop = fifo_data;
   assign if_fx.full  = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int oh2i(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction

   // Raises pndng on bus 0, checks the pop strobe, and leaves off just after the pop edge.
   task automatic launch(input int dev, input logic [15:0] data);
      man_pndng[0][dev] = 1'b1;
      man_dpop[0][dev]  = data;
      @(negedge clk);
      chk("launch_pop", 32'(if_rr.pop[0]), 32'(1) << dev);
      chk("launch_busy", 32'(if_rr.busy[0]), 32'h1);
      @(negedge clk);
      man_pndng[0][dev] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      man_pndng = '0;
      man_full  = '0;
      man_dpop  = '0;
      use_fifo  = 1'b0;
      fifo_clr  = 1'b1;
      reset     = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_pop", 32'(if_rr.pop), 32'h0);
      chk("rst_push", 32'(if_rr.push), 32'h0);
      chk("rst_busy", 32'(if_rr.busy), 32'h0);
      chk("rst_drop", 32'(if_rr.drop_cnt), 32'h0);
      chk("rst_dpush", 32'(if_rr.D_push[0][2]), 32'h0);
      chk("rst_fx_busy", 32'(if_fx.busy), 32'h0);
      reset = 1'b0;
      @(negedge clk);

      // Unicast dev1 -> dev2
      launch(1, 16'h0234);
      chk("uni_busy_route", 32'(if_rr.busy[0]), 32'h1);
      chk("uni_pop_off", 32'(if_rr.pop[0]), 32'h0);
      @(negedge clk);
      chk("uni_busy_deliver", 32'(if_rr.busy[0]), 32'h1);
      chk("uni_push_early", 32'(if_rr.push[0]), 32'h0);
      @(negedge clk);
      chk("uni_push", 32'(if_rr.push[0]), 32'h4);
      chk("uni_dpush", 32'(if_rr.D_push[0][2]), 32'h0234);
      chk("uni_busy_end", 32'(if_rr.busy[0]), 32'h0);
      @(negedge clk);
      chk("uni_push_once", 32'(if_rr.push[0]), 32'h0);

      // Broadcast from dev2
      launch(2, 16'hFFAA);
      @(negedge clk);
      @(negedge clk);
      chk("bc_push", 32'(if_rr.push[0]), 32'hB);
      chk("bc_dpush", 32'(if_rr.D_push[0][3]), 32'hFFAA);
      chk("bc_drop", 32'(if_rr.drop_cnt[0]), 32'h0);
      @(negedge clk);
      chk("bc_push_once", 32'(if_rr.push[0]), 32'h0);

      // Invalid destination and saturation
      launch(0, 16'h07C3);
      @(negedge clk);
      chk("inv_drop1", 32'(if_rr.drop_cnt[0]), 32'h1);
      chk("inv_busy", 32'(if_rr.busy[0]), 32'h0);
      chk("inv_push", 32'(if_rr.push[0]), 32'h0);
      for (int n = 2; n <= 300; n++) begin
         launch(0, 16'h07C3);
         @(negedge clk);
         if (n == 2)   chk("inv_drop2", 32'(if_rr.drop_cnt[0]), 32'h2);
         if (n == 255) chk("inv_drop255", 32'(if_rr.drop_cnt[0]), 32'hFF);
      end
      chk("inv_drop_sat", 32'(if_rr.drop_cnt[0]), 32'hFF);
      chk("inv_push_none", 32'(if_rr.push[0]), 32'h0);

      // Back-pressure on a unicast to dev3
      man_full[0][3] = 1'b1;
      launch(0, 16'h0311);
      @(negedge clk);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("bp_uni_stall", 32'(if_rr.push[0]), 32'h0);
         chk("bp_uni_busy", 32'(if_rr.busy[0]), 32'h1);
      end
      man_full[0][3] = 1'b0;
      @(negedge clk);
      chk("bp_uni_push", 32'(if_rr.push[0]), 32'h8);
      chk("bp_uni_dpush", 32'(if_rr.D_push[0][3]), 32'h0311);
      @(negedge clk);

      // Back-pressure on a broadcast: no partial delivery
      man_full[0][1] = 1'b1;
      launch(0, 16'hFF55);
      @(negedge clk);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_bc_stall", 32'(if_rr.push[0]), 32'h0);
      end
      man_full[0][1] = 1'b0;
      @(negedge clk);
      chk("bp_bc_push", 32'(if_rr.push[0]), 32'hE);
      chk("bp_bc_dpush", 32'(if_rr.D_push[0][0]), 32'hFF55);
      @(negedge clk);

      // Reset while stalled in DELIVER
      man_full[0][1] = 1'b1;
      launch(2, 16'h0199);
      @(negedge clk);
      @(negedge clk);
      chk("mid_stall", 32'(if_rr.push[0]), 32'h0);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_pop", 32'(if_rr.pop), 32'h0);
      chk("mid_rst_push", 32'(if_rr.push), 32'h0);
      chk("mid_rst_busy", 32'(if_rr.busy), 32'h0);
      chk("mid_rst_drop", 32'(if_rr.drop_cnt), 32'h0);
      reset = 1'b0;
      man_full = '0;
      @(negedge clk);
      chk("mid_no_old_push", 32'(if_rr.push[0]), 32'h0);
      chk("mid_idle", 32'(if_rr.busy[0]), 32'h0);
      man_pndng[0][3] = 1'b1;
      man_dpop[0][3]  = 16'h0155;
      man_pndng[0][0] = 1'b1;
      man_dpop[0][0]  = 16'h0266;
      @(negedge clk);
      chk("mid_first_grant", 32'(if_rr.pop[0]), 32'h1);
      @(negedge clk);
      man_pndng[0][0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("mid_push0", 32'(if_rr.push[0]), 32'h4);
      chk("mid_dpush0", 32'(if_rr.D_push[0][2]), 32'h0266);
      @(negedge clk);
      chk("mid_second_grant", 32'(if_rr.pop[0]), 32'h8);
      @(negedge clk);
      man_pndng[0][3] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("mid_push3", 32'(if_rr.push[0]), 32'h2);
      chk("mid_dpush3", 32'(if_rr.D_push[0][1]), 32'h0155);
      @(negedge clk);
      chk("bus1_push", 32'(if_rr.push[1]), 32'h0);
      chk("bus1_busy", 32'(if_rr.busy[1]), 32'h0);
      chk("bus1_pop", 32'(if_rr.pop[1]), 32'h0);

      // Fairness: round-robin on dut_rr, fixed priority on dut_fx
      reset    = 1'b1;
      fifo_clr = 1'b1;
      use_fifo = 1'b1;
      @(negedge clk);
      reset    = 1'b0;
      fifo_clr = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (|if_rr.pop[0]) g_rr.push_back(oh2i(if_rr.pop[0]));
         if (|if_fx.pop[0]) g_fx.push_back(oh2i(if_fx.pop[0]));
         chk("fair_bus1_idle", 32'(if_rr.busy[1]), 32'h0);
      end
      chk("rr_grant_count", 32'(g_rr.size()), 32'd12);
      chk("fx_grant_count", 32'(g_fx.size()), 32'd12);
      for (int k = 0; k < g_rr.size() && k < 12; k++)
         chk("rr_order", 32'(g_rr[k]), 32'(k % 4));
      for (int k = 0; k < g_fx.size() && k < 12; k++)
         chk("fx_order", 32'(g_fx[k]), 32'(k / 3));
      chk("fair_drop", 32'(if_rr.drop_cnt[0]), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
